multdiv_sequencer: RTL

Control block that sequences the shared multi-cycle multiply/divide unit for R-type `mul` (ALU op 00110) and `div` (ALU op 00111) instructions.
- Detects the instruction, stalls the pipeline and launches the unit with captured operands.
- Waits for the unit's ready handshake, then produces a single-cycle register writeback.
- Errors and watchdog timeouts are redirected to the status register $r30.

---
 rtl/multdiv_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared multi-cycle mul/div unit: stalls issue, launches the unit, writes back the result.
// Optional watchdog abort is compiled in with `define MULTDIV_TIMEOUT_EN.
module multdiv_sequencer #(
    parameter int          TIMEOUT    = 40,
    parameter logic [31:0] STATUS_MUL = 32'd4,
    parameter logic [31:0] STATUS_DIV = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [4:0]  opcode,
    input  logic [4:0]  aluop,
    input  logic [4:0]  rd,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        stall,
    output logic        md_start,
    output logic        md_is_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WB   = 2'd2
    } state_t;

`ifdef MULTDIV_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    // Abort is decided one cycle ahead so the unit gets exactly TIMEOUT BUSY cycles.
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);
    localparam logic [4:0] STATUS_REG   = 5'd30;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] a_reg, b_reg, result_reg;
    logic        is_div_reg, exc_reg;
    logic [4:0]  rd_reg;

    logic hit;
    logic first_cycle;
    logic ready_q;
    logic wdog_abort;
    logic capture;
    logic finish;

    assign hit = valid_in && (opcode == 5'b00000)
              && ((aluop == 5'b00110) || (aluop == 5'b00111));

    assign first_cycle = (cnt_reg == 6'd0);
    // A ready coincident with the launch pulse belongs to a previous job and is ignored.
    assign ready_q     = md_ready && !first_cycle;
    assign wdog_abort  = WDOG_EN && (cnt_reg == TIMEOUT_LAST) && !ready_q;

    assign capture = (state_reg == ST_IDLE) && hit;
    assign finish  = (state_reg == ST_BUSY) && (ready_q || wdog_abort);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 6'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (hit) begin
                    state_next = ST_BUSY;
                    cnt_next   = 6'd0;
                end
            end
            ST_BUSY: begin
                if (cnt_reg != 6'd63) begin
                    cnt_next = cnt_reg + 6'd1;
                end
                if (ready_q || wdog_abort) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand / destination capture, held for the whole operation
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            is_div_reg <= 1'b0;
            rd_reg     <= 5'd0;
        end else if (capture) begin
            a_reg      <= operand_a;
            b_reg      <= operand_b;
            is_div_reg <= aluop[0];
            rd_reg     <= rd;
        end
    end

    // Result capture; a watchdog abort is recorded as an exception
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_reg <= 32'd0;
            exc_reg    <= 1'b0;
        end else if (finish) begin
            result_reg <= ready_q ? md_result : 32'd0;
            exc_reg    <= ready_q ? md_exception : 1'b1;
        end
    end

    // Output logic
    always_comb begin
        stall    = 1'b0;
        md_start = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = rd_reg;
        wb_data  = 32'd0;
        busy     = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                stall = hit && reset;
            end
            ST_BUSY: begin
                stall    = 1'b1;
                md_start = first_cycle;
            end
            ST_WB: begin
                if (exc_reg) begin
                    wb_valid = 1'b1;
                    wb_rd    = STATUS_REG;
                    wb_data  = is_div_reg ? STATUS_DIV : STATUS_MUL;
                end else begin
                    // Writes to $r0 are suppressed
                    wb_valid = (rd_reg != 5'd0);
                    wb_data  = result_reg;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign md_a      = a_reg;
    assign md_b      = b_reg;
    assign md_is_div = is_div_reg;

endmodule
